// File: rtl/lce_pkg.sv
// Shared constants and FSM encoding for the local-mean stage.
// LCE_MEAN_ROUND_EN widens the divider dividend for round-to-nearest means.
package lce_pkg;

  localparam int IMG_W    = 150;
  localparam int PAD      = 22;
  localparam int WIN      = 2 * PAD + 1;
  localparam int PAD_W    = IMG_W + 2 * PAD;
  localparam int WIN2     = WIN * WIN;
  localparam int SRC_BASE = 22500;
  localparam int DST_BASE = 60136;
  localparam int ADDR_W   = 17;
  localparam int RD_LAT   = 3;
  localparam int PH_W     = $clog2(RD_LAT + 1);

  localparam int CS_W  = 14;
  localparam int WS_W  = 19;
  localparam int DSR_W = 12;
  localparam int Q_W   = 8;
  localparam int DIV_N = 20;

`ifdef LCE_MEAN_ROUND_EN
  localparam int DVD_W = 20;
`else
  localparam int DVD_W = 19;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_HINIT,
    S_DIV,
    S_WRITE,
    S_SLIDE,
    S_RUPD,
    S_DONE
  } state_t;

endpackage

// File: rtl/win_divider.sv
// Serial restoring divider by a fixed window area.
// One quotient bit per cycle, DIV_N cycles per division.
module win_divider
  import lce_pkg::*;
#(
  parameter int DIVISOR = WIN2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);

  localparam int CW = $clog2(DIV_N);
  localparam logic [DSR_W-1:0] DSR = DSR_W'(DIVISOR);

  logic [DSR_W-1:0] rem;
  logic [DIV_N-1:0] qs;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [DSR_W:0]   trial;
  logic             fit;

  assign trial    = {rem, qs[DIV_N-1]};
  assign fit      = trial >= {1'b0, DSR};
  assign quotient = qs[Q_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      qs   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem  <= '0;
        qs   <= DIV_N'(dividend);
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= fit ? DSR_W'(trial - {1'b0, DSR})
                   : trial[DSR_W-1:0];
        qs  <= {qs[DIV_N-2:0], fit};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DIV_N - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/local_mean_window.sv
// Box-window local mean over the padded image using running column sums.
// LCE_MEAN_ROUND_EN selects round-to-nearest instead of truncation.
module local_mean_window #(
  parameter int IMG_W    = lce_pkg::IMG_W,
  parameter int PAD      = lce_pkg::PAD,
  parameter int SRC_BASE = lce_pkg::SRC_BASE,
  parameter int DST_BASE = lce_pkg::DST_BASE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mean_start,
  output logic                       mean_completed,
  input  logic [7:0]                 dout,
  output logic                       ren,
  output logic                       wen,
  output logic [lce_pkg::ADDR_W-1:0] addr,
  output logic [7:0]                 din
);
  import lce_pkg::*;

  localparam int WIN   = 2 * PAD + 1;
  localparam int WIN2  = WIN * WIN;
  localparam int PAD_W = IMG_W + 2 * PAD;
  localparam int IDX_W = $clog2(PAD_W);

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [ADDR_W-1:0] adr_t;
  typedef logic [PH_W-1:0]   ph_t;

  state_t state, state_n;

  idx_t i, j, r, c;
  ph_t  ph;
  logic sel;
  logic [7:0] nval;
  logic [CS_W-1:0] colsum [PAD_W];
  logic [WS_W-1:0] winsum;

  logic div_go, div_start, div_done;
  logic [Q_W-1:0]   quot;
  logic [DVD_W-1:0] dividend;

  logic smp, last_i, last_j, last_c, last_r;

  assign smp    = ph == ph_t'(RD_LAT);
  assign last_i = i == idx_t'(WIN - 1);
  assign last_j = j == idx_t'(PAD_W - 1);
  assign last_c = c == idx_t'(IMG_W - 1);
  assign last_r = r == idx_t'(IMG_W - 1);

  function automatic adr_t src_adr(idx_t row, idx_t col);
    return adr_t'(SRC_BASE) + adr_t'(row) * adr_t'(PAD_W)
         + adr_t'(col);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (mean_start) state_n = S_INIT;
      S_INIT:  if (smp && last_j && last_i) state_n = S_HINIT;
      S_HINIT: if (last_i) state_n = S_DIV;
      S_DIV:   if (div_done) state_n = S_WRITE;
      S_WRITE: begin
        if (!last_c)     state_n = S_SLIDE;
        else if (last_r) state_n = S_DONE;
        else             state_n = S_RUPD;
      end
      S_SLIDE: state_n = S_DIV;
      S_RUPD:  if (smp && sel && last_j) state_n = S_HINIT;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ren            = 1'b0;
    wen            = 1'b0;
    addr           = '0;
    din            = '0;
    mean_completed = 1'b0;
    unique case (state)
      S_INIT: begin
        ren  = ph == '0;
        addr = src_adr(i, j);
      end
      S_RUPD: begin
        // new row first (sel=0), then the row leaving the window
        ren  = ph == '0;
        addr = src_adr(sel ? r : idx_t'(r + idx_t'(WIN)), j);
      end
      S_WRITE: begin
        wen  = 1'b1;
        addr = adr_t'(DST_BASE) + adr_t'(r) * adr_t'(IMG_W)
             + adr_t'(c);
        din  = quot;
      end
      S_DONE:  mean_completed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i      <= '0;
      j      <= '0;
      r      <= '0;
      c      <= '0;
      ph     <= '0;
      sel    <= 1'b0;
      nval   <= '0;
      winsum <= '0;
      div_go <= 1'b0;
      for (int n = 0; n < PAD_W; n++) colsum[n] <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (smp) begin
            ph        <= '0;
            colsum[j] <= colsum[j] + CS_W'(dout);
            if (last_j) begin
              j <= '0;
              i <= last_i ? '0 : i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
            if (last_j && last_i) begin
              r      <= '0;
              winsum <= '0;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        S_HINIT: begin
          winsum <= winsum + WS_W'(colsum[i]);
          if (last_i) begin
            i <= '0;
            c <= '0;
          end else begin
            i <= i + 1'b1;
          end
        end
        S_DIV: begin
          if (!div_go)  div_go <= 1'b1;
          if (div_done) div_go <= 1'b0;
        end
        S_WRITE: begin
          if (last_c && !last_r) begin
            j   <= '0;
            ph  <= '0;
            sel <= 1'b0;
          end
        end
        S_SLIDE: begin
          winsum <= winsum
                  + WS_W'(colsum[c + idx_t'(WIN)])
                  - WS_W'(colsum[c]);
          c <= c + 1'b1;
        end
        S_RUPD: begin
          if (smp) begin
            ph  <= '0;
            sel <= ~sel;
            if (!sel) begin
              nval <= dout;
            end else begin
              colsum[j] <= colsum[j] + CS_W'(nval)
                         - CS_W'(dout);
              if (last_j) begin
                j      <= '0;
                i      <= '0;
                r      <= r + 1'b1;
                winsum <= '0;
              end else begin
                j <= j + 1'b1;
              end
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_start = (state == S_DIV) && !div_go;

`ifdef LCE_MEAN_ROUND_EN
  assign dividend = DVD_W'(winsum) + DVD_W'(WIN2 / 2);
`else
  assign dividend = winsum;
`endif

  win_divider #(
    .DIVISOR(WIN2)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .quotient (quot),
    .done     (div_done)
  );

endmodule

// File: tb/tb_local_mean_window.sv
// Directed bench for local_mean_window on a reduced 6x6 image, PAD=2.
// Includes a negedge BRAM model with fixed read latency and a bus monitor.
module tb_local_mean_window;

  localparam int IMG_W  = 6;
  localparam int PAD    = 2;
  localparam int WIN    = 2 * PAD + 1;
  localparam int PAD_W  = IMG_W + 2 * PAD;
  localparam int WIN2   = WIN * WIN;
  localparam int SRC    = 22500;
  localparam int DST    = 60136;
  localparam int RD_LAT = 3;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int LIMIT  = 20000;

`ifdef LCE_MEAN_ROUND_EN
  localparam int C01 = 161;
  localparam int C11 = 129;
`else
  localparam int C01 = 160;
  localparam int C11 = 128;
`endif

  typedef logic [16:0] adr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mean_start;
  logic       mean_completed;
  logic [7:0] dout;
  logic       ren;
  logic       wen;
  adr_t       addr;
  logic [7:0] din;

  local_mean_window #(
    .IMG_W    (IMG_W),
    .PAD      (PAD),
    .SRC_BASE (SRC),
    .DST_BASE (DST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mean_start     (mean_start),
    .mean_completed (mean_completed),
    .dout           (dout),
    .ren            (ren),
    .wen            (wen),
    .addr           (addr),
    .din            (din)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:131071];
  int   res     [NPIX];
  bit   written [NPIX];

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int cd = 0;
  logic [7:0] pend = '0;
  int nacc = 0;
  int nwr = 0;
  int first_wa = -1;
  int last_wr = -1;
  int done_cyc = -1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // BRAM model and bus monitor, evaluated mid-cycle
  always @(negedge clk) begin
    int wi;
    cyc++;
    if (cd > 0) begin
      cd--;
      dout = (cd == 0) ? pend : 8'($urandom);
    end else begin
      dout = 8'($urandom);
    end
    if (ren || wen) begin
      nacc++;
      chk("ren_wen_excl", int'(ren && wen), 0);
    end
    if (ren) begin
      chk("rd_overlap", int'(cd != 0), 0);
      pend = mem[addr];
      cd   = RD_LAT;
    end
    if (wen) begin
      chk("wr_done_early", int'(mean_completed), 0);
      if (nwr == 0) first_wa = int'(addr);
      wi = int'(addr) - DST;
      chk("wr_range", int'(wi >= 0 && wi < NPIX), 1);
      if (wi >= 0 && wi < NPIX) begin
        chk("wr_once", int'(written[wi]), 0);
        written[wi] = 1'b1;
        res[wi]     = int'(din);
      end
      nwr++;
      last_wr = cyc;
    end
    if (mean_completed && done_cyc < 0) done_cyc = cyc;
  end

  function automatic int exp_mean(int r, int c);
    int s = 0;
    for (int y = 0; y < WIN; y++)
      for (int x = 0; x < WIN; x++)
        s += int'(mem[adr_t'(SRC + (r + y) * PAD_W + c + x)]);
`ifdef LCE_MEAN_ROUND_EN
    s += WIN2 / 2;
`endif
    return s / WIN2;
  endfunction

  task automatic fill(input int kind, input logic [7:0] v);
    for (int y = 0; y < PAD_W; y++)
      for (int x = 0; x < PAD_W; x++) begin
        logic [7:0] p;
        case (kind)
          0:       p = v;
          1:       p = (y < WIN && x < WIN) ? v : 8'd0;
          2:       p = (y == 2*PAD && x == 2*PAD) ? v : 8'd0;
          default: p = 8'($urandom);
        endcase
        mem[adr_t'(SRC + y * PAD_W + x)] = p;
      end
  endtask

  task automatic clear_log();
    for (int k = 0; k < NPIX; k++) begin
      res[k]     = -1;
      written[k] = 1'b0;
    end
    nwr      = 0;
    first_wa = -1;
    last_wr  = -1;
    done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cd    = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_and_wait(input string tag, input bit poke);
    int n = 0;
    clear_log();
    @(negedge clk);
    mean_start = 1'b1;
    @(negedge clk);
    mean_start = 1'b0;
    if (poke) begin
      repeat (300) @(negedge clk);
      mean_start = 1'b1;
      repeat (7) @(negedge clk);
      mean_start = 1'b0;
    end
    while (!mean_completed && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, int'(mean_completed), 1);
    repeat (20) @(negedge clk);
    chk({tag, "_nwr"}, nwr, NPIX);
    chk({tag, "_done_after_wr"}, int'(done_cyc > last_wr), 1);
  endtask

  task automatic cmp_const(input string tag, input int v);
    for (int k = 0; k < NPIX; k++) chk(tag, res[k], v);
  endtask

  task automatic cmp_model(input string tag);
    for (int r = 0; r < IMG_W; r++)
      for (int c = 0; c < IMG_W; c++)
        chk(tag, res[r * IMG_W + c], exp_mean(r, c));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n      = 1'b0;
    mean_start = 1'b0;
    dout       = '0;
    for (int k = 0; k < 131072; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ren", int'(ren), 0);
    chk("rst_wen", int'(wen), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_done", int'(mean_completed), 0);
    rst_n = 1'b1;

    fill(0, 8'd100);
    do_reset();
    start_and_wait("flat100", 1'b1);
    cmp_const("flat100_pix", 100);

    fill(0, 8'd255);
    do_reset();
    start_and_wait("flat255", 1'b0);
    cmp_const("flat255_pix", 255);

    fill(1, 8'd201);
    do_reset();
    start_and_wait("corner", 1'b0);
    chk("corner_00", res[0], 201);
    chk("corner_01", res[1], C01);
    chk("corner_10", res[IMG_W], C01);
    chk("corner_11", res[IMG_W + 1], C11);
    cmp_model("corner_pix");

    fill(2, 8'd255);
    do_reset();
    start_and_wait("single", 1'b0);
    chk("single_first_addr", first_wa, DST);
    chk("single_00", res[0], 10);
    chk("single_44", res[4 * IMG_W + 4], 10);
    chk("single_05", res[5], 0);
    chk("single_55", res[NPIX - 1], 0);
    cmp_model("single_pix");

    // abort during the column-sum update of r=3
    fill(3, 8'd0);
    do_reset();
    clear_log();
    @(negedge clk);
    mean_start = 1'b1;
    @(negedge clk);
    mean_start = 1'b0;
    n = 0;
    while (!(ren && addr == adr_t'(SRC + (3 + WIN) * PAD_W))
           && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", int'(n < LIMIT), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ren", int'(ren), 0);
    chk("abort_wen", int'(wen), 0);
    chk("abort_addr", int'(addr), 0);
    chk("abort_din", int'(din), 0);
    chk("abort_done", int'(mean_completed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cd    = 0;
    base  = nacc;
    repeat (100) @(negedge clk);
    chk("abort_idle_noacc", nacc - base, 0);
    start_and_wait("restart", 1'b0);
    cmp_model("restart_pix");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
